// File: rtl/multimode_modulator_if.sv
// Sample/result bus for multimode_modulator: baseband sample, carrier word and
// mode in with a valid/ready handshake; I/Q carrier samples out with a strobe.
interface multimode_modulator_if #(
   parameter int PHASE_WIDTH = 32,
   parameter int INPUT_WIDTH = 8,
   parameter int DATA_WIDTH  = 12
);
   logic        [PHASE_WIDTH-1:0] Fre_word;
   logic        [1:0]             mode;
   logic signed [INPUT_WIDTH-1:0] data_in;
   logic                          in_valid;
   logic                          in_ready;
   logic signed [DATA_WIDTH-1:0]  I_out;
   logic signed [DATA_WIDTH-1:0]  Q_out;
   logic                          out_valid;

   modport master (
      output Fre_word, mode, data_in, in_valid,
      input  in_ready, I_out, Q_out, out_valid
   );

   modport slave (
      input  Fre_word, mode, data_in, in_valid,
      output in_ready, I_out, Q_out, out_valid
   );
endinterface

// File: rtl/multimode_modulator.sv
// AM/FM/PM modulator: phase accumulator feeding an iterative CORDIC rotator.
// Optional MODULATOR_GAIN_COMP_EN adds a SCALE state removing the CORDIC gain.
module multimode_modulator #(
   parameter int ITERATIONS  = 16,
   parameter int PHASE_WIDTH = 32,
   parameter int INPUT_WIDTH = 8,
   parameter int DATA_WIDTH  = 12,
   parameter int FM_SHIFT    = 16,
   parameter int PM_SHIFT    = 22,
   parameter int AM_SHIFT    = 2
) (
   input logic                  clk_in,
   input logic                  RST,
   multimode_modulator_if.slave bus
);
   localparam int XW      = DATA_WIDTH + 2;
   localparam int CW      = 5;
   localparam int A_FULL  = 1 << (DATA_WIDTH - 2);
   localparam int OUT_MAX = (1 << (DATA_WIDTH - 1)) - 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCALE, S_ROTATE, S_DONE} state_t;
   typedef enum logic [1:0] {M_AM, M_FM, M_PM, M_CW} mode_t;

   state_t                        r_state, w_next;
   mode_t                         r_mode;
   logic        [CW-1:0]          r_iter;
   logic        [PHASE_WIDTH-1:0] r_phase_acc, r_fre, r_z;
   logic signed [INPUT_WIDTH-1:0] r_data;
   logic signed [XW-1:0]          r_x, r_y;
   logic signed [DATA_WIDTH-1:0]  r_i_out, r_q_out;
   logic                          r_out_valid;

   logic signed [PHASE_WIDTH-1:0] w_d_ph, w_fm_off, w_pm_off;
   logic        [PHASE_WIDTH-1:0] w_inc, w_phase_new, w_angle, w_z0, w_atan;
   logic signed [XW-1:0]          w_x0;
   logic                          w_fold;
   int                            w_amp;

   function automatic logic [PHASE_WIDTH-1:0] atan_at(input logic [CW-1:0] i);
      logic [31:0] t;
      case (i)
         5'd0:  t = 32'h2000_0000;  5'd1:  t = 32'h12E4_051E;
         5'd2:  t = 32'h09FB_385B;  5'd3:  t = 32'h0511_11D4;
         5'd4:  t = 32'h028B_0D43;  5'd5:  t = 32'h0145_D7E1;
         5'd6:  t = 32'h00A2_F61E;  5'd7:  t = 32'h0051_7C55;
         5'd8:  t = 32'h0028_BE53;  5'd9:  t = 32'h0014_5F2F;
         5'd10: t = 32'h000A_2F98;  5'd11: t = 32'h0005_17CC;
         5'd12: t = 32'h0002_8BE6;  5'd13: t = 32'h0001_45F3;
         5'd14: t = 32'h0000_A2FA;  5'd15: t = 32'h0000_517D;
         5'd16: t = 32'h0000_28BE;  5'd17: t = 32'h0000_145F;
         5'd18: t = 32'h0000_0A30;  5'd19: t = 32'h0000_0518;
         5'd20: t = 32'h0000_028C;  5'd21: t = 32'h0000_0146;
         5'd22: t = 32'h0000_00A3;  5'd23: t = 32'h0000_0051;
         default: t = '0;
      endcase
      // table is in 2^32-per-turn units; rescale to the configured phase width
      return PHASE_WIDTH'(({32'd0, t} << PHASE_WIDTH) >> 32);
   endfunction

   // x/y carry two fractional guard bits; drop them with rounding on output
   function automatic logic signed [DATA_WIDTH-1:0] sat_round(input logic signed [XW-1:0] v);
      int t;
      t = (int'(v) + 2) >>> 2;
      if (t > OUT_MAX)       t = OUT_MAX;
      else if (t < -OUT_MAX - 1) t = -OUT_MAX - 1;
      return DATA_WIDTH'(t);
   endfunction

   assign w_atan        = atan_at(r_iter);
   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.I_out     = r_i_out;
   assign bus.Q_out     = r_q_out;
   assign bus.out_valid = r_out_valid;

   always_comb begin
      w_d_ph      = PHASE_WIDTH'(r_data);
      w_fm_off    = (r_mode == M_FM) ? (w_d_ph <<< FM_SHIFT) : '0;
      w_pm_off    = (r_mode == M_PM) ? (w_d_ph <<< PM_SHIFT) : '0;
      w_inc       = r_fre + w_fm_off;
      w_phase_new = r_phase_acc + w_inc;
      w_angle     = w_phase_new + w_pm_off;
      w_amp       = A_FULL;
      if (r_mode == M_AM) begin
         w_amp = A_FULL / 2 + (int'(r_data) <<< AM_SHIFT);
         if (w_amp < 0)           w_amp = 0;
         else if (w_amp > A_FULL) w_amp = A_FULL;
      end
      w_fold = w_angle[PHASE_WIDTH-1] ^ w_angle[PHASE_WIDTH-2];
      w_x0   = w_fold ? -XW'(w_amp <<< 2) : XW'(w_amp <<< 2);
      w_z0   = w_fold ? {~w_angle[PHASE_WIDTH-1], w_angle[PHASE_WIDTH-2:0]} : w_angle;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.in_valid) w_next = S_LOAD;
`ifdef MODULATOR_GAIN_COMP_EN
         S_LOAD:   w_next = S_SCALE;
         S_SCALE:  w_next = S_ROTATE;
`else
         S_LOAD:   w_next = S_ROTATE;
`endif
         S_ROTATE: if (r_iter == CW'(ITERATIONS - 1)) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         r_phase_acc <= '0;
         r_fre       <= '0;
         r_mode      <= M_AM;
         r_data      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_iter      <= '0;
         r_i_out     <= '0;
         r_q_out     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.in_valid) begin
               r_fre  <= bus.Fre_word;
               r_mode <= mode_t'(bus.mode);
               r_data <= bus.data_in;
            end
            S_LOAD: begin
               r_phase_acc <= w_phase_new;
               r_x         <= w_x0;
               r_y         <= '0;
               r_z         <= w_z0;
               r_iter      <= '0;
            end
`ifdef MODULATOR_GAIN_COMP_EN
            S_SCALE: r_x <= XW'((32'(r_x) * 32'sd19898) >>> 15);
`endif
            S_ROTATE: begin
               if (!r_z[PHASE_WIDTH-1]) begin
                  r_x <= r_x - (r_y >>> r_iter);
                  r_y <= r_y + (r_x >>> r_iter);
                  r_z <= r_z - w_atan;
               end else begin
                  r_x <= r_x + (r_y >>> r_iter);
                  r_y <= r_y - (r_x >>> r_iter);
                  r_z <= r_z + w_atan;
               end
               r_iter <= r_iter + CW'(1);
            end
            S_DONE: begin
               r_i_out     <= sat_round(r_x);
               r_q_out     <= sat_round(r_y);
               r_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
